bp_be_debug_instr_encoder: RTL and testbench
============================================

// Module: bp_be_debug_instr_encoder
// PURPOSE
//  Converts debug-module "access register" abstract commands into RV64 CSR-format instruction words and
//  injects them into the BE issue path ahead of the instruction decoder, via valid/ready. Tracks
//  retirement of the injected words and returns one completion/cmderr per command. Data moves through
//  dscratch0; dscratch1 holds the saved scratch GPR for CSR accesses.
// PARAMETERS
//  dscratch0_addr_p  12'h7B2  CSR used as the data exchange register
//  dscratch1_addr_p  12'h7B3  CSR used to save/restore the scratch GPR
//  scratch_gpr_p     8        GPR (s0) clobbered and restored during CSR access
//  timeout_p         1024     cycles allowed in DRAIN before abort
// PORTS
//  clk_i           in   1   clock
//  reset_n_i       in   1   asynchronous active-low reset
//  cmd_v_i         in   1   abstract command valid
//  cmd_ready_o     out  1   command accepted when cmd_v_i & cmd_ready_o
//  cmd_regno_i     in   16  debug regno: 0x0000-0x0FFF CSR, 0x1000-0x101F GPR
//  cmd_write_i     in   1   1 = write register from dscratch0, 0 = read into dscratch0
//  cmd_transfer_i  in   1   0 = no transfer, complete immediately
//  cmd_aarsize_i   in   3   access size; only 3 (64b) supported
//  instr_v_o       out  1   injected instruction valid
//  instr_o         out  32  RV64 instruction word
//  instr_ready_i   in   1   issue path accepts instr_o
//  commit_v_i      in   1   one injected instruction retired this cycle
//  exc_v_i         in   1   injected instruction raised an exception
//  done_v_o        out  1   one-cycle command-complete pulse
//  cmderr_o        out  3   valid with done_v_o: 0 none, 2 not supported, 3 exception
//  busy_o          out  1   high from acceptance until the done_v_o cycle inclusive
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready_o=1, instr_v_o=0, done_v_o=0, cmderr_o=0, busy_o=0, counters 0.
//  IDLE: cmd_ready_o=1. On accept, latch fields and decode:
//   transfer=0 -> DONE, cmderr 0; aarsize!=3 or regno outside both ranges -> DONE, cmderr 2;
//   else load sequence length N and go to ISSUE with issue_cnt=0, commit_cnt=0.
//  Sequences (r=regno[4:0], c=regno[11:0], s=scratch_gpr_p, d0/d1=dscratch0/1 addr), N words:
//   GPR read  N=1: CSRRW x0,d0,xr     GPR write N=1: CSRRS xr,d0,x0
//   CSR read  N=4: CSRRW x0,d1,xs; CSRRS xs,c,x0; CSRRW x0,d0,xs; CSRRS xs,d1,x0
//   CSR write N=4: CSRRW x0,d1,xs; CSRRS xs,d0,x0; CSRRW x0,c,xs; CSRRS xs,d1,x0
//  Encoding: {csr[11:0],rs1[4:0],funct3,rd[4:0],7'b1110011}; CSRRW funct3=001, CSRRS funct3=010.
//  ISSUE: instr_v_o=1, instr_o=word[issue_cnt], registered and held stable until instr_ready_i.
//   Handshake increments issue_cnt; after word N-1 accepted -> DRAIN. No words issued outside ISSUE.
//  commit_v_i counted in ISSUE and DRAIN; commit_cnt==N (incl. same-cycle commit) -> DONE, cmderr 0.
//  exc_v_i in ISSUE/DRAIN (any cycle, also coincident with handshake or commit): drop instr_v_o next
//   cycle, -> DONE cmderr 3. exc_v_i wins over a simultaneous final commit.
//  DRAIN timeout: timeout_p cycles without reaching N commits -> DONE cmderr 3.
//  commit_v_i/exc_v_i while IDLE or DONE are ignored (no count, no state change).
//  DONE: done_v_o=1 for exactly one cycle with cmderr_o; cmd_ready_o=0; -> IDLE. Back-to-back
//   commands: next accept earliest cycle after DONE.
//  Latency: transfer=0 / unsupported -> done_v_o 1 cycle after accept. GPR access with ready held
//   high and commit 2 cycles after issue -> done_v_o 4 cycles after accept.
//  Reset asserted mid-command: abandon sequence, all outputs to reset values, no done_v_o emitted.
// STRUCTURE
//  bp_be_pkg: bp_be_dbg_cmderr_e {e_cmderr_none=0, e_cmderr_unsup=2, e_cmderr_exc=3};
//   state enum {e_dbg_idle, e_dbg_issue, e_dbg_drain, e_dbg_done}.
//  bp_common_rv64_pkg: `RV64_SYSTEM_OP, funct3 constants for CSRRW/CSRRS, regno range constants.
//  Sub-module bp_be_csr_instr_gen: combinational {funct3,csr,rs1,rd} -> 32b word; one instance,
//   fed by a 2b step index mux over the latched command.
// TESTING
//  GPR read x5, ready=1, commit 2 cyc later -> instr_o=0x7B229073 once; done_v_o, cmderr 0.
//  GPR write x7 -> instr_o=0x7B2023F3; done after commit_v_i; cmderr 0.
//  CSR read 0x300 with ready toggled 1/0 -> 0x7B341073,0x30002473,0x7B241073,0x7B302473 in order, each
//   held stable while ready=0; done after 4th commit.
//  regno 0x1020 or aarsize=2 -> no instr_v_o; done_v_o next cycle, cmderr 2; transfer=0 -> cmderr 0.
//  CSR write, exc_v_i on 2nd word's commit cycle -> instr_v_o drops, done cmderr 3; no 3rd word.
//  Async reset_n_i low mid-DRAIN -> outputs reset immediately; no done_v_o; next command runs cleanly.

Source files
------------

// File: rtl/bp_be_debug_instr_encoder_pkg.sv
// Purpose : shared types and RV64 constants for the debug abstract-command
//           instruction encoder.
// Contents: cmderr and FSM state enums, SYSTEM opcode, CSR funct3 values,
//           debug regno ranges and the only supported access size.
package bp_be_debug_instr_encoder_pkg;

    typedef enum logic [2:0] {
        e_cmderr_none  = 3'd0,
        e_cmderr_unsup = 3'd2,
        e_cmderr_exc   = 3'd3
    } bp_be_dbg_cmderr_e;

    typedef enum logic [1:0] {
        e_dbg_idle,
        e_dbg_issue,
        e_dbg_drain,
        e_dbg_done
    } bp_be_dbg_state_e;

    localparam logic [6:0]  rv64_system_op      = 7'b1110011;
    localparam logic [2:0]  rv64_funct3_csrrw   = 3'b001;
    localparam logic [2:0]  rv64_funct3_csrrs   = 3'b010;

    localparam logic [15:0] dbg_regno_csr_max   = 16'h0FFF;
    localparam logic [15:0] dbg_regno_gpr_min   = 16'h1000;
    localparam logic [15:0] dbg_regno_gpr_max   = 16'h101F;

    localparam logic [2:0]  dbg_aarsize_64      = 3'd3;

endpackage

// File: rtl/bp_be_debug_instr_encoder_csr_instr_gen.sv
// Purpose : combinational packer for an RV64 Zicsr instruction word.
// Ports   : i_funct3 - CSRRW/CSRRS selector
//           i_csr    - 12b CSR address
//           i_rs1    - source GPR index
//           i_rd     - destination GPR index
//           o_instr  - 32b instruction word
module bp_be_csr_instr_gen
    import bp_be_debug_instr_encoder_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [11:0] i_csr,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rd,
    output logic [31:0] o_instr
);

    assign o_instr = {i_csr, i_rs1, i_funct3, i_rd, rv64_system_op};

endmodule

// File: rtl/bp_be_debug_instr_encoder.sv
// Purpose : turns debug "access register" abstract commands into CSR-format
//           instruction words, injects them into the issue path over
//           valid/ready, tracks their retirement and reports one completion
//           (with cmderr) per command. Data is exchanged through dscratch0;
//           dscratch1 preserves the scratch GPR during CSR accesses.
// Ports   : clk_i, reset_n_i (async, active-low)
//           cmd_v_i/cmd_ready_o + cmd_regno_i, cmd_write_i, cmd_transfer_i,
//             cmd_aarsize_i                 - abstract command handshake
//           instr_v_o/instr_ready_i, instr_o - injected instruction stream
//           commit_v_i, exc_v_i             - retirement / exception of
//                                             injected words
//           done_v_o, cmderr_o              - one-cycle completion pulse
//           busy_o                          - command in flight
module bp_be_debug_instr_encoder
    import bp_be_debug_instr_encoder_pkg::*;
#(
    parameter logic [11:0] dscratch0_addr_p = 12'h7B2,
    parameter logic [11:0] dscratch1_addr_p = 12'h7B3,
    parameter int          scratch_gpr_p    = 8,
    parameter int          timeout_p        = 1024
)
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cmd_v_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_regno_i,
    input  logic        cmd_write_i,
    input  logic        cmd_transfer_i,
    input  logic [2:0]  cmd_aarsize_i,
    output logic        instr_v_o,
    output logic [31:0] instr_o,
    input  logic        instr_ready_i,
    input  logic        commit_v_i,
    input  logic        exc_v_i,
    output logic        done_v_o,
    output logic [2:0]  cmderr_o,
    output logic        busy_o
);

    localparam int                    lp_timer_w    = $clog2(timeout_p + 1);
    localparam logic [lp_timer_w-1:0] lp_timer_last = lp_timer_w'(timeout_p - 1);
    localparam logic [4:0]            lp_scratch    = 5'(scratch_gpr_p);

    bp_be_dbg_state_e      r_state, w_state_n;
    bp_be_dbg_cmderr_e     r_cmderr, w_cmderr_n;
    logic [2:0]            r_len;
    logic [2:0]            r_issue_cnt;
    logic [2:0]            r_commit_cnt;
    logic [lp_timer_w-1:0] r_timer;
    logic [11:0]           r_regno;
    logic                  r_write;
    logic                  r_is_csr;
    logic [31:0]           r_instr;

    logic        w_idle, w_issue, w_drain, w_active;
    logic        w_cmd_is_csr, w_cmd_is_gpr, w_cmd_unsup;
    logic        w_accept, w_hs;
    logic [2:0]  w_commit_cnt_inc;
    logic        w_all_committed, w_last_issue, w_timeout;
    logic [11:0] w_sel_regno;
    logic        w_sel_write, w_sel_csr;
    logic [1:0]  w_step;
    logic [2:0]  w_funct3;
    logic [11:0] w_csr;
    logic [4:0]  w_rs1, w_rd;
    logic [31:0] w_gen_instr;

    assign w_idle   = (r_state == e_dbg_idle);
    assign w_issue  = (r_state == e_dbg_issue);
    assign w_drain  = (r_state == e_dbg_drain);
    assign w_active = w_issue | w_drain;

    assign w_cmd_is_csr = (cmd_regno_i <= dbg_regno_csr_max);
    assign w_cmd_is_gpr = (cmd_regno_i >= dbg_regno_gpr_min) && (cmd_regno_i <= dbg_regno_gpr_max);
    assign w_cmd_unsup  = (cmd_aarsize_i != dbg_aarsize_64) || !(w_cmd_is_csr || w_cmd_is_gpr);

    assign w_accept = w_idle & cmd_v_i;
    assign w_hs     = w_issue & instr_ready_i;

    // A commit arriving this cycle counts toward completion immediately.
    assign w_commit_cnt_inc = commit_v_i ? (r_commit_cnt + 3'd1) : r_commit_cnt;
    assign w_all_committed  = w_active && (w_commit_cnt_inc == r_len);
    assign w_last_issue     = (r_issue_cnt == (r_len - 3'd1));
    assign w_timeout        = w_drain && (r_timer == lp_timer_last);

    // The generator always produces the word to be registered next: word 0
    // from the raw command while idle, otherwise the word after the one
    // currently being presented.
    assign w_sel_regno = w_idle ? cmd_regno_i[11:0] : r_regno;
    assign w_sel_write = w_idle ? cmd_write_i       : r_write;
    assign w_sel_csr   = w_idle ? w_cmd_is_csr      : r_is_csr;
    assign w_step      = w_idle ? 2'd0 : (r_issue_cnt[1:0] + 2'd1);

    always_comb begin
        w_funct3 = rv64_funct3_csrrw;
        w_csr    = dscratch0_addr_p;
        w_rs1    = 5'd0;
        w_rd     = 5'd0;
        if (!w_sel_csr) begin
            if (w_sel_write) begin
                w_funct3 = rv64_funct3_csrrs;
                w_rd     = w_sel_regno[4:0];
            end else begin
                w_rs1    = w_sel_regno[4:0];
            end
        end else begin
            // Even steps move the scratch GPR into a CSR, odd steps pull a
            // CSR into the scratch GPR.
            if (w_step[0]) begin
                w_funct3 = rv64_funct3_csrrs;
                w_rd     = lp_scratch;
            end else begin
                w_rs1    = lp_scratch;
            end
            case (w_step)
                2'd1:    w_csr = w_sel_write ? dscratch0_addr_p : w_sel_regno;
                2'd2:    w_csr = w_sel_write ? w_sel_regno : dscratch0_addr_p;
                default: w_csr = dscratch1_addr_p;
            endcase
        end
    end

    bp_be_csr_instr_gen u_csr_instr_gen (
        .i_funct3 (w_funct3),
        .i_csr    (w_csr),
        .i_rs1    (w_rs1),
        .i_rd     (w_rd),
        .o_instr  (w_gen_instr)
    );

    always_comb begin
        w_state_n   = r_state;
        w_cmderr_n  = r_cmderr;
        cmd_ready_o = 1'b0;
        instr_v_o   = 1'b0;
        done_v_o    = 1'b0;
        cmderr_o    = 3'd0;
        busy_o      = 1'b1;
        case (r_state)
            e_dbg_idle: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_v_i) begin
                    if (!cmd_transfer_i) begin
                        w_state_n  = e_dbg_done;
                        w_cmderr_n = e_cmderr_none;
                    end else if (w_cmd_unsup) begin
                        w_state_n  = e_dbg_done;
                        w_cmderr_n = e_cmderr_unsup;
                    end else begin
                        w_state_n  = e_dbg_issue;
                    end
                end
            end
            e_dbg_issue: begin
                instr_v_o = 1'b1;
                // Exception takes priority over any coincident commit or handshake.
                if (exc_v_i) begin
                    w_state_n  = e_dbg_done;
                    w_cmderr_n = e_cmderr_exc;
                end else if (w_all_committed) begin
                    w_state_n  = e_dbg_done;
                    w_cmderr_n = e_cmderr_none;
                end else if (w_hs && w_last_issue) begin
                    w_state_n  = e_dbg_drain;
                end
            end
            e_dbg_drain: begin
                if (exc_v_i) begin
                    w_state_n  = e_dbg_done;
                    w_cmderr_n = e_cmderr_exc;
                end else if (w_all_committed) begin
                    w_state_n  = e_dbg_done;
                    w_cmderr_n = e_cmderr_none;
                end else if (w_timeout) begin
                    w_state_n  = e_dbg_done;
                    w_cmderr_n = e_cmderr_exc;
                end
            end
            e_dbg_done: begin
                done_v_o  = 1'b1;
                cmderr_o  = r_cmderr;
                w_state_n = e_dbg_idle;
            end
            default: begin
                w_state_n = e_dbg_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= e_dbg_idle;
            r_cmderr     <= e_cmderr_none;
            r_len        <= 3'd0;
            r_issue_cnt  <= 3'd0;
            r_commit_cnt <= 3'd0;
            r_timer      <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cmderr <= w_cmderr_n;
            if (w_accept) begin
                r_len        <= w_cmd_is_csr ? 3'd4 : 3'd1;
                r_issue_cnt  <= 3'd0;
                r_commit_cnt <= 3'd0;
            end else begin
                if (w_hs) begin
                    r_issue_cnt <= r_issue_cnt + 3'd1;
                end
                if (w_active && commit_v_i) begin
                    r_commit_cnt <= w_commit_cnt_inc;
                end
            end
            r_timer <= w_drain ? (r_timer + lp_timer_w'(1)) : '0;
        end
    end

    // Command fields and the presented word carry no reset: they are only
    // observed while the FSM says they are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_regno  <= cmd_regno_i[11:0];
            r_write  <= cmd_write_i;
            r_is_csr <= w_cmd_is_csr;
        end
        if (w_accept || w_hs) begin
            r_instr <= w_gen_instr;
        end
    end

    assign instr_o = r_instr;

endmodule

// File: tb/tb_bp_be_debug_instr_encoder.sv
module tb_bp_be_debug_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i;
    logic        cmd_ready_o;
    logic [15:0] cmd_regno_i;
    logic        cmd_write_i;
    logic        cmd_transfer_i;
    logic [2:0]  cmd_aarsize_i;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic        instr_ready_i;
    logic        commit_v_i;
    logic        exc_v_i;
    logic        done_v_o;
    logic [2:0]  cmderr_o;
    logic        busy_o;

    always #5 clk = ~clk;

    bp_be_debug_instr_encoder #(.timeout_p(16)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .cmd_v_i        (cmd_v_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_regno_i    (cmd_regno_i),
        .cmd_write_i    (cmd_write_i),
        .cmd_transfer_i (cmd_transfer_i),
        .cmd_aarsize_i  (cmd_aarsize_i),
        .instr_v_o      (instr_v_o),
        .instr_o        (instr_o),
        .instr_ready_i  (instr_ready_i),
        .commit_v_i     (commit_v_i),
        .exc_v_i        (exc_v_i),
        .done_v_o       (done_v_o),
        .cmderr_o       (cmderr_o),
        .busy_o         (busy_o)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_instr[$];
    logic [2:0]  exp_err[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_w = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%08h while nothing was expected", name, act);
    endtask

    // Scoreboard monitor: words are checked on handshake, completions on done.
    always @(negedge clk) begin
        if (reset_n_i && instr_v_o) begin
            if (hold_v) chk("instr_hold", instr_o, hold_w);
            if (instr_ready_i) begin
                if (exp_instr.size() == 0) unexpected("instr_extra", instr_o);
                else chk("instr_word", instr_o, exp_instr.pop_front());
                hold_v = 1'b0;
            end else begin
                hold_v = 1'b1;
                hold_w = instr_o;
            end
        end else begin
            hold_v = 1'b0;
        end
        if (done_v_o) begin
            if (exp_err.size() == 0) unexpected("done_extra", 32'(cmderr_o));
            else chk("cmderr", 32'(cmderr_o), 32'(exp_err.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [15:0] regno, input logic wr,
                             input logic tr, input logic [2:0] size);
        int n = 0;
        while (!cmd_ready_o && n < 20) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
        cmd_v_i        = 1'b1;
        cmd_regno_i    = regno;
        cmd_write_i    = wr;
        cmd_transfer_i = tr;
        cmd_aarsize_i  = size;
        step();
        cmd_v_i = 1'b0;
    endtask

    // rmode: 0 ready always high, 1 ready toggles, 2 ready drops after two handshakes.
    // dly: commit this many cycles after each handshake (0 = never commit).
    // exc_k: raise exc_v_i together with the k-th commit (0 = never).
    task automatic run_seq(input int rmode, input int dly, input int exc_k,
                           input int max_cyc, output int cycles);
        logic [3:0] hist;
        int         nhs;
        int         ncom;
        bit         seen;
        logic       hs_now;
        hist = 4'd0; nhs = 0; ncom = 0; seen = 0; cycles = 0;
        while (!seen && cycles < max_cyc) begin
            if (done_v_o) begin
                seen = 1;
            end else begin
                instr_ready_i = (rmode == 0) || (rmode == 1 && (cycles % 2) == 0) ||
                                (rmode == 2 && nhs < 2);
                commit_v_i = (dly == 1) ? hist[0] : (dly == 2) ? hist[1] : 1'b0;
                exc_v_i    = 1'b0;
                if (commit_v_i) begin
                    ncom++;
                    if (ncom == exc_k) exc_v_i = 1'b1;
                end
                hs_now = instr_v_o && instr_ready_i;
                hist   = {hist[2:0], hs_now};
                if (hs_now) nhs++;
                step();
                cycles++;
            end
        end
        if (done_v_o) seen = 1;
        commit_v_i    = 1'b0;
        exc_v_i       = 1'b0;
        instr_ready_i = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    int cyc;

    initial begin
        cmd_v_i = 1'b0; cmd_regno_i = 16'd0; cmd_write_i = 1'b0; cmd_transfer_i = 1'b0;
        cmd_aarsize_i = 3'd0; instr_ready_i = 1'b0; commit_v_i = 1'b0; exc_v_i = 1'b0;
        reset_n_i = 1'b1;
        #1 reset_n_i = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_instr_v",   32'(instr_v_o),   32'd0);
        chk("rst_done_v",    32'(done_v_o),    32'd0);
        chk("rst_cmderr",    32'(cmderr_o),    32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;
        step();

        // GPR read x5, commit two cycles after issue
        exp_instr.push_back(32'h7B229073); exp_err.push_back(3'd0);
        do_accept(16'h1005, 1'b0, 1'b1, 3'd3);
        chk("gpr_rd_busy_early", 32'(busy_o), 32'd1);
        run_seq(0, 2, 0, 40, cyc);
        chk("gpr_rd_latency", 32'(cyc), 32'd3);
        chk("done_busy", 32'(busy_o), 32'd1);
        chk("done_cmd_ready", 32'(cmd_ready_o), 32'd0);
        step();
        chk("after_done_ready", 32'(cmd_ready_o), 32'd1);
        chk("after_done_busy", 32'(busy_o), 32'd0);

        // GPR write x7
        exp_instr.push_back(32'h7B2023F3); exp_err.push_back(3'd0);
        do_accept(16'h1007, 1'b1, 1'b1, 3'd3);
        run_seq(0, 1, 0, 40, cyc);

        // CSR read 0x300 with ready toggling
        exp_instr.push_back(32'h7B341073); exp_instr.push_back(32'h30002473);
        exp_instr.push_back(32'h7B241073); exp_instr.push_back(32'h7B302473);
        exp_err.push_back(3'd0);
        do_accept(16'h0300, 1'b0, 1'b1, 3'd3);
        run_seq(1, 1, 0, 60, cyc);

        // Unsupported regno, unsupported size, no transfer
        exp_err.push_back(3'd2);
        do_accept(16'h1020, 1'b0, 1'b1, 3'd3);
        run_seq(0, 1, 0, 10, cyc);
        chk("unsup_regno_latency", 32'(cyc), 32'd0);
        exp_err.push_back(3'd2);
        do_accept(16'h1005, 1'b0, 1'b1, 3'd2);
        run_seq(0, 1, 0, 10, cyc);
        chk("unsup_size_latency", 32'(cyc), 32'd0);
        exp_err.push_back(3'd0);
        do_accept(16'h1020, 1'b0, 1'b0, 3'd2);
        run_seq(0, 1, 0, 10, cyc);
        chk("no_xfer_latency", 32'(cyc), 32'd0);

        // CSR write 0x300, exception on the 2nd word's commit
        exp_instr.push_back(32'h7B341073); exp_instr.push_back(32'h7B202473);
        exp_err.push_back(3'd3);
        do_accept(16'h0300, 1'b1, 1'b1, 3'd3);
        run_seq(2, 1, 2, 40, cyc);
        chk("exc_instr_drop", 32'(instr_v_o), 32'd0);
        repeat (3) step();

        // DRAIN timeout (timeout_p = 16): no commits at all
        exp_instr.push_back(32'h7B229073); exp_err.push_back(3'd3);
        do_accept(16'h1005, 1'b0, 1'b1, 3'd3);
        run_seq(0, 0, 0, 60, cyc);
        chk("timeout_latency", 32'(cyc), 32'd17);

        // Async reset in DRAIN
        exp_instr.push_back(32'h7B2023F3);
        do_accept(16'h1007, 1'b1, 1'b1, 3'd3);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("midrst_instr_v",   32'(instr_v_o),   32'd0);
        chk("midrst_busy",      32'(busy_o),      32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("midrst_done_v",    32'(done_v_o),    32'd0);
        @(posedge clk);
        #3 reset_n_i = 1'b1;
        step();

        // Retire/exception pulses while idle are ignored
        commit_v_i = 1'b1; exc_v_i = 1'b1;
        step(); step();
        commit_v_i = 1'b0; exc_v_i = 1'b0;
        chk("idle_ignore_busy",  32'(busy_o),      32'd0);
        chk("idle_ignore_ready", 32'(cmd_ready_o), 32'd1);

        // Clean CSR write after reset
        exp_instr.push_back(32'h7B341073); exp_instr.push_back(32'h7B202473);
        exp_instr.push_back(32'h30041073); exp_instr.push_back(32'h7B302473);
        exp_err.push_back(3'd0);
        do_accept(16'h0300, 1'b1, 1'b1, 3'd3);
        run_seq(0, 1, 0, 40, cyc);
        repeat (3) step();

        chk("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
        chk("done_queue_drained",  32'(exp_err.size()),   32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
